// File: rtl/aes_gcm_sequencer.sv
// Purpose : Sequences one AES-GCM message (INIT, AAD blocks, PT blocks, LEN) into issue slots for a non-stalling AES/GHASH pipeline.
// Latency : 1 cycle from an accepted AAD/PT transfer, or from the INIT/LEN state cycle, to its registered o_valid slot.
// Backpr. : o_aad_ready/o_pt_ready depend on state only; a cycle without a transfer issues an empty slot and holds all state.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   i_start, i_iv                  message start pulse (accepted in IDLE only) and 96-bit IV
//   i_aad_blocks, i_pt_blocks      full 128-bit block counts, captured with i_start
//   i_aad/_valid, o_aad_ready      AAD block stream
//   i_pt/_valid, o_pt_ready        plaintext block stream
//   o_valid, o_phase               issue slot strobe and phase tag (1 INIT, 2 AAD, 3 PT, 4 LEN)
//   o_h .. o_instance_size         128-bit pipeline operands, zero when o_valid is low
//   o_busy, o_done                 message in flight / one-cycle completion pulse
module aes_gcm_sequencer #(
  parameter int N_BLK_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [95:0]        i_iv,
  input  logic [N_BLK_W-1:0] i_aad_blocks,
  input  logic [N_BLK_W-1:0] i_pt_blocks,
  input  logic [127:0]       i_aad,
  input  logic               i_aad_valid,
  output logic               o_aad_ready,
  input  logic [127:0]       i_pt,
  input  logic               i_pt_valid,
  output logic               o_pt_ready,
  output logic               o_valid,
  output logic [2:0]         o_phase,
  output logic [127:0]       o_h,
  output logic [127:0]       o_encrypted_j0,
  output logic [127:0]       o_encrypted_cb,
  output logic [127:0]       o_aad,
  output logic [127:0]       o_plain_text,
  output logic [127:0]       o_instance_size,
  output logic               o_busy,
  output logic               o_done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_AAD  = 3'd2,
    S_PT   = 3'd3,
    S_LEN  = 3'd4,
    S_DONE = 3'd5
  } state_e;

  state_e state_q, state_d;

  // Message context
  logic [95:0]        iv_q, iv_d;
  logic [N_BLK_W-1:0] aad_cnt_q, aad_cnt_d;   // original counts, kept for the LEN slot
  logic [N_BLK_W-1:0] pt_cnt_q, pt_cnt_d;
  logic [N_BLK_W-1:0] aad_rem_q, aad_rem_d;   // blocks still to accept
  logic [N_BLK_W-1:0] pt_rem_q, pt_rem_d;
  logic [31:0]        ctr_q, ctr_d;           // inc32 counter word of the counter block

  // Registered slot outputs
  logic         valid_q, valid_d;
  logic [2:0]   phase_q, phase_d;
  logic [127:0] h_q, h_d;
  logic [127:0] j0_q, j0_d;
  logic [127:0] cb_q, cb_d;
  logic [127:0] aad_q, aad_d;
  logic [127:0] pt_q, pt_d;
  logic [127:0] size_q, size_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic start_acc;
  logic aad_xfer;
  logic pt_xfer;
  logic [63:0] aad_bits;
  logic [63:0] pt_bits;

  assign o_aad_ready = (state_q == S_AAD);
  assign o_pt_ready  = (state_q == S_PT);

  assign start_acc = (state_q == S_IDLE) && i_start;
  assign aad_xfer  = o_aad_ready && i_aad_valid;
  assign pt_xfer   = o_pt_ready && i_pt_valid;

  // Block counts to bit lengths (x128)
  assign aad_bits = 64'(aad_cnt_q) << 7;
  assign pt_bits  = 64'(pt_cnt_q) << 7;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (i_start) state_d = S_INIT;
      S_INIT: begin
        if (aad_cnt_q != '0)     state_d = S_AAD;
        else if (pt_cnt_q != '0) state_d = S_PT;
        else                     state_d = S_LEN;
      end
      S_AAD: begin
        if (aad_xfer && (aad_rem_q == N_BLK_W'(1))) begin
          state_d = (pt_cnt_q != '0) ? S_PT : S_LEN;
        end
      end
      S_PT: begin
        if (pt_xfer && (pt_rem_q == N_BLK_W'(1))) state_d = S_LEN;
      end
      S_LEN:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Context next-state: capture on start, count down on transfers
  always_comb begin
    iv_d      = iv_q;
    aad_cnt_d = aad_cnt_q;
    pt_cnt_d  = pt_cnt_q;
    aad_rem_d = aad_rem_q;
    pt_rem_d  = pt_rem_q;
    ctr_d     = ctr_q;
    if (start_acc) begin
      iv_d      = i_iv;
      aad_cnt_d = i_aad_blocks;
      pt_cnt_d  = i_pt_blocks;
      aad_rem_d = i_aad_blocks;
      pt_rem_d  = i_pt_blocks;
      ctr_d     = 32'd2;            // counter 1 is reserved for J0
    end
    if (aad_xfer) aad_rem_d = aad_rem_q - N_BLK_W'(1);
    if (pt_xfer) begin
      pt_rem_d = pt_rem_q - N_BLK_W'(1);
      ctr_d    = ctr_q + 32'd1;     // wraps in the low word only
    end
  end

  // Output logic: slot contents for the next cycle
  always_comb begin
    valid_d = 1'b0;
    phase_d = 3'd0;
    h_d     = '0;
    j0_d    = '0;
    cb_d    = '0;
    aad_d   = '0;
    pt_d    = '0;
    size_d  = '0;
    done_d  = (state_q == S_DONE);
    // Busy covers the done-pulse cycle as well as the message itself
    busy_d  = (state_d != S_IDLE) || (state_q == S_DONE);
    case (state_q)
      S_INIT: begin
        valid_d = 1'b1;
        phase_d = 3'd1;
        j0_d    = {iv_q, 32'd1};
        cb_d    = {iv_q, 32'd1};
      end
      S_AAD: begin
        if (aad_xfer) begin
          valid_d = 1'b1;
          phase_d = 3'd2;
          aad_d   = i_aad;
        end
      end
      S_PT: begin
        if (pt_xfer) begin
          valid_d = 1'b1;
          phase_d = 3'd3;
          pt_d    = i_pt;
          cb_d    = {iv_q, ctr_q};
        end
      end
      S_LEN: begin
        valid_d = 1'b1;
        phase_d = 3'd4;
        size_d  = {aad_bits, pt_bits};
      end
      default: ;
    endcase
  end

  // Context and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      iv_q      <= '0;
      aad_cnt_q <= '0;
      pt_cnt_q  <= '0;
      aad_rem_q <= '0;
      pt_rem_q  <= '0;
      ctr_q     <= '0;
      valid_q   <= 1'b0;
      phase_q   <= 3'd0;
      h_q       <= '0;
      j0_q      <= '0;
      cb_q      <= '0;
      aad_q     <= '0;
      pt_q      <= '0;
      size_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      iv_q      <= iv_d;
      aad_cnt_q <= aad_cnt_d;
      pt_cnt_q  <= pt_cnt_d;
      aad_rem_q <= aad_rem_d;
      pt_rem_q  <= pt_rem_d;
      ctr_q     <= ctr_d;
      valid_q   <= valid_d;
      phase_q   <= phase_d;
      h_q       <= h_d;
      j0_q      <= j0_d;
      cb_q      <= cb_d;
      aad_q     <= aad_d;
      pt_q      <= pt_d;
      size_q    <= size_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign o_valid         = valid_q;
  assign o_phase         = phase_q;
  assign o_h             = h_q;
  assign o_encrypted_j0  = j0_q;
  assign o_encrypted_cb  = cb_q;
  assign o_aad           = aad_q;
  assign o_plain_text    = pt_q;
  assign o_instance_size = size_q;
  assign o_busy          = busy_q;
  assign o_done          = done_q;

endmodule

// File: tb/tb_aes_gcm_sequencer.sv
// Purpose : Randomized self-checking bench for aes_gcm_sequencer against an expected-slot queue model.
// Latency : Slots are sampled on the falling edge, half a cycle after they are registered.
// Backpr. : Stream valids are driven held-high, randomly gapped, or toggled depending on the message mode.
module tb_aes_gcm_sequencer;

  localparam int NB = 16;

  logic           clk;
  logic           rst;
  logic           i_start;
  logic [95:0]    i_iv;
  logic [NB-1:0]  i_aad_blocks;
  logic [NB-1:0]  i_pt_blocks;
  logic [127:0]   i_aad;
  logic           i_aad_valid;
  logic           o_aad_ready;
  logic [127:0]   i_pt;
  logic           i_pt_valid;
  logic           o_pt_ready;
  logic           o_valid;
  logic [2:0]     o_phase;
  logic [127:0]   o_h;
  logic [127:0]   o_encrypted_j0;
  logic [127:0]   o_encrypted_cb;
  logic [127:0]   o_aad;
  logic [127:0]   o_plain_text;
  logic [127:0]   o_instance_size;
  logic           o_busy;
  logic           o_done;

  aes_gcm_sequencer #(.N_BLK_W(NB)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_start         (i_start),
    .i_iv            (i_iv),
    .i_aad_blocks    (i_aad_blocks),
    .i_pt_blocks     (i_pt_blocks),
    .i_aad           (i_aad),
    .i_aad_valid     (i_aad_valid),
    .o_aad_ready     (o_aad_ready),
    .i_pt            (i_pt),
    .i_pt_valid      (i_pt_valid),
    .o_pt_ready      (o_pt_ready),
    .o_valid         (o_valid),
    .o_phase         (o_phase),
    .o_h             (o_h),
    .o_encrypted_j0  (o_encrypted_j0),
    .o_encrypted_cb  (o_encrypted_cb),
    .o_aad           (o_aad),
    .o_plain_text    (o_plain_text),
    .o_instance_size (o_instance_size),
    .o_busy          (o_busy),
    .o_done          (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]   ph;
    logic [127:0] j0;
    logic [127:0] cb;
    logic [127:0] aad;
    logic [127:0] pt;
    logic [127:0] size;
  } slot_t;

  slot_t exp_q[$];
  int    n_chk  = 0;
  int    n_fail = 0;

  task automatic chk_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic ops_nonzero();
    return (|o_phase) | (|o_h) | (|o_encrypted_j0) | (|o_encrypted_cb) |
           (|o_aad) | (|o_plain_text) | (|o_instance_size);
  endfunction

  // mode 0: valids held high, 1: random gaps, 2: PT valid toggles 1,0,1,...
  task automatic run_msg(input logic [95:0] iv, input int na, input int np, input int mode,
                         input bit preload, input bit mid_start);
    logic [127:0] aad_blk[$];
    logic [127:0] pt_blk[$];
    slot_t        s;
    logic [31:0]  c;
    int           ai, pi, cyc, nslot, len_cyc, last_pt_cyc;
    bit           done_seen, tog, mid_done;

    // Reference: the full expected slot sequence for this message
    for (int i = 0; i < na; i++) aad_blk.push_back(rnd128());
    for (int i = 0; i < np; i++) pt_blk.push_back(rnd128());
    exp_q.delete();
    s = '0; s.ph = 3'd1; s.j0 = {iv, 32'd1}; s.cb = {iv, 32'd1};
    exp_q.push_back(s);
    for (int i = 0; i < na; i++) begin
      s = '0; s.ph = 3'd2; s.aad = aad_blk[i];
      exp_q.push_back(s);
    end
    c = preload ? 32'hFFFF_FFFF : 32'd2;
    for (int i = 0; i < np; i++) begin
      s = '0; s.ph = 3'd3; s.pt = pt_blk[i]; s.cb = {iv, c};
      exp_q.push_back(s);
      c = c + 32'd1;
    end
    s = '0; s.ph = 3'd4;
    s.size = {64'(na) * 64'd128, 64'(np) * 64'd128};
    exp_q.push_back(s);

    @(negedge clk);
    i_start      = 1'b1;
    i_iv         = iv;
    i_aad_blocks = NB'(na);
    i_pt_blocks  = NB'(np);
    i_aad_valid  = 1'b0;
    i_pt_valid   = 1'b0;
    @(posedge clk);

    ai = 0; pi = 0; cyc = 0; nslot = 0; len_cyc = -100; last_pt_cyc = -1;
    done_seen = 1'b0; tog = 1'b1; mid_done = 1'b0;
    while (!done_seen && cyc < 300) begin
      @(negedge clk);
      if (preload && cyc == 0) force dut.ctr_q = 32'hFFFF_FFFF;
      if (preload && cyc == 1) release dut.ctr_q;

      chk_eq("busy", 128'(o_busy), 128'(1));
      chk_eq("ready_excl", 128'(o_aad_ready & o_pt_ready), 128'(0));
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          chk_eq("extra_slot", 128'(o_phase), 128'(0));
        end else begin
          s = exp_q.pop_front();
          chk_eq("phase", 128'(o_phase), 128'(s.ph));
          chk_eq("h", o_h, 128'(0));
          chk_eq("j0", o_encrypted_j0, s.j0);
          chk_eq("cb", o_encrypted_cb, s.cb);
          chk_eq("aad", o_aad, s.aad);
          chk_eq("pt", o_plain_text, s.pt);
          chk_eq("size", o_instance_size, s.size);
          if (mode == 0) chk_eq("slot_cycle", 128'(cyc), 128'(nslot + 1));
          if (mode == 2 && s.ph == 3'd3) begin
            if (last_pt_cyc >= 0) chk_eq("pt_spacing", 128'(cyc - last_pt_cyc), 128'(2));
            last_pt_cyc = cyc;
          end
          if (s.ph == 3'd4) len_cyc = cyc;
          nslot++;
        end
      end else begin
        chk_eq("idle_zero", 128'(ops_nonzero()), 128'(0));
      end
      if (o_done) begin
        chk_eq("done_after_len", 128'(cyc - len_cyc), 128'(1));
        done_seen = 1'b1;
      end

      // Drive inputs for the next rising edge
      if (mid_start && o_aad_ready && !mid_done) begin
        i_start      = 1'b1;
        i_iv         = ~iv;
        i_aad_blocks = NB'(5);
        i_pt_blocks  = NB'(7);
        mid_done     = 1'b1;
      end else begin
        i_start = 1'b0;
      end
      i_aad_valid = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      i_aad       = (ai < na) ? aad_blk[ai] : rnd128();
      if (mode == 1)      i_pt_valid = ($urandom_range(0, 2) != 0);
      else if (mode == 2) i_pt_valid = o_pt_ready ? tog : 1'b1;
      else                i_pt_valid = 1'b1;
      if (mode == 2 && o_pt_ready) tog = ~tog;
      i_pt = (pi < np) ? pt_blk[pi] : rnd128();
      if (i_aad_valid && o_aad_ready) ai++;
      if (i_pt_valid && o_pt_ready) pi++;
      cyc++;
    end
    chk_eq("msg_completed", 128'(done_seen), 128'(1));
    i_start     = 1'b0;
    i_aad_valid = 1'b0;
    i_pt_valid  = 1'b0;
    @(negedge clk);
    chk_eq("busy_after_done", 128'(o_busy), 128'(0));
    chk_eq("valid_after_done", 128'(o_valid), 128'(0));
    chk_eq("slots_left", 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    // Reset held together with a start request: reset must win
    rst          = 1'b1;
    i_start      = 1'b1;
    i_iv         = 96'h5;
    i_aad_blocks = NB'(1);
    i_pt_blocks  = NB'(1);
    i_aad        = '0;
    i_aad_valid  = 1'b0;
    i_pt         = '0;
    i_pt_valid   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_eq("rst_valid", 128'(o_valid), 128'(0));
    chk_eq("rst_ops", 128'(ops_nonzero()), 128'(0));
    chk_eq("rst_busy", 128'(o_busy), 128'(0));
    chk_eq("rst_done", 128'(o_done), 128'(0));
    chk_eq("rst_ready", 128'({o_aad_ready, o_pt_ready}), 128'(0));
    rst     = 1'b0;
    i_start = 1'b0;
    @(negedge clk);
    chk_eq("rst_prio_busy", 128'(o_busy), 128'(0));
    chk_eq("rst_prio_valid", 128'(o_valid), 128'(0));

    // Directed scenarios
    run_msg(96'h1, 1, 2, 0, 1'b0, 1'b0);
    run_msg({$urandom, $urandom, $urandom}, 0, 0, 0, 1'b0, 1'b0);
    run_msg({$urandom, $urandom, $urandom}, 0, 3, 2, 1'b0, 1'b0);
    run_msg({$urandom, $urandom, $urandom}, 0, 2, 0, 1'b1, 1'b0);
    run_msg({$urandom, $urandom, $urandom}, 2, 2, 0, 1'b0, 1'b1);

    // Reset in the middle of the PT phase
    @(negedge clk);
    i_start      = 1'b1;
    i_iv         = {$urandom, $urandom, $urandom};
    i_aad_blocks = NB'(0);
    i_pt_blocks  = NB'(3);
    i_pt_valid   = 1'b1;
    i_pt         = rnd128();
    @(posedge clk);
    @(negedge clk);
    i_start = 1'b0;
    k = 0;
    while (k < 20 && !(o_valid && o_phase == 3'd3)) begin
      @(negedge clk);
      k++;
    end
    chk_eq("rst_mid_reached_pt", 128'(o_valid && o_phase == 3'd3), 128'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_eq("rst_mid_valid", 128'(o_valid), 128'(0));
    chk_eq("rst_mid_ops", 128'(ops_nonzero()), 128'(0));
    chk_eq("rst_mid_busy", 128'(o_busy), 128'(0));
    chk_eq("rst_mid_ready", 128'({o_aad_ready, o_pt_ready}), 128'(0));
    repeat (2) begin
      @(negedge clk);
      chk_eq("rst_mid_no_slot", 128'(o_valid), 128'(0));
    end
    i_pt_valid = 1'b0;
    run_msg({$urandom, $urandom, $urandom}, 1, 1, 0, 1'b0, 1'b0);

    // Randomized messages with random stream gaps
    for (int t = 0; t < 8; t++) begin
      run_msg({$urandom, $urandom, $urandom}, $urandom_range(0, 4), $urandom_range(0, 4),
              1, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
